reg_file_multiport: RTL and testbench
=====================================

Name: reg_file_multiport

Overview:
- Parametrised next-generation MIPS register file for the ID stage.
- Adds configurable read-port count, a hardwired-zero option, and an optional write-to-read bypass.
- Adds a debug dump engine that streams every register to the debug unit over a valid/ready handshake.
- Sits between the ID decode logic, the WB-stage write port and the debug/UART unit.

Parameters:
- DATA_WIDTH, 32, width of each register.
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH registers.
- NUM_READ, 2, number of independent read ports (1..4).
- HARDWIRE_ZERO, 1, when 1 register 0 always reads 0 and ignores writes.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_write_enable  in  1  write strobe.
- i_write_reg  in  ADDR_WIDTH  write address.
- i_data_write  in  DATA_WIDTH  write data.
- i_read_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k in bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- o_read_data  out  NUM_READ*DATA_WIDTH  packed read data, same packing as i_read_addr.
- i_dump_start  in  1  single-cycle request to start a full register dump.
- i_dump_ready  in  1  consumer ready.
- o_dump_valid  out  1  dump word valid.
- o_dump_idx  out  ADDR_WIDTH  index of the current dump word.
- o_dump_data  out  DATA_WIDTH  value of the current dump word.
- o_dump_done  out  1  one-cycle pulse after the last word is accepted.
- o_dump_busy  out  1  high while the dump engine is not IDLE.

Behaviour:
- Reset: i_reset sampled high at a rising edge has these effects:
  - all DEPTH registers become 0;
  - FSM goes to IDLE and the dump index to 0;
  - o_dump_valid, o_dump_done and o_dump_busy become 0.
  - Reset has priority over write and dump activity, including mid-dump: the transfer is aborted and no done pulse is issued.
- Write: on a rising edge with i_write_enable=1, registers[i_write_reg] <= i_data_write.
  - If HARDWIRE_ZERO=1 and i_write_reg=0, the write is dropped.
- Read: combinational, zero latency; o_read_data port k = registers[addr_k].
  - If HARDWIRE_ZERO=1 and addr_k=0, the port outputs 0 regardless of stored contents or bypass.
- Same-cycle write and read of one address: read returns the old value unless the bypass feature is enabled.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: i_dump_start=1 -> SEND with idx=0. Otherwise stay.
  - SEND:
    - o_dump_valid=1, o_dump_idx=idx, o_dump_data=registers[idx] (combinational from current contents; HARDWIRE_ZERO applies at idx 0).
    - Handshake completes when o_dump_valid and i_dump_ready are both 1 at a rising edge.
    - On completion with idx<DEPTH-1: idx<=idx+1, stay in SEND.
    - On completion with idx=DEPTH-1: go to DONE.
    - With i_dump_ready=0: idx, valid and data index are held stable. Data may change only if a write hits that index.
  - DONE: o_dump_done=1 for exactly one cycle, then IDLE.
  - o_dump_busy=1 in SEND and DONE.
  - i_dump_start while busy is ignored; it is not queued.
  - Writes during a dump are allowed. Words not yet accepted reflect the latest contents; no snapshot is taken.
- Throughput: with i_dump_ready held high, DEPTH words are accepted on DEPTH consecutive edges; o_dump_done rises on the next cycle.
- Index arithmetic: idx is ADDR_WIDTH wide and never wraps, because the transition at DEPTH-1 leaves SEND.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: if i_write_enable=1 and i_write_reg equals a read port's address, that port outputs i_data_write in the same cycle.
  - This also applies to the dump data when i_write_reg equals idx.
  - Hardwired zero still wins for address 0.
- Not defined: no forwarding; reads show the stored value, and the new value is visible from the cycle after the write edge.

Decomposition:
- Package reg_file_pkg holds:
  - the dump state typedef/localparams (IDLE=2'd0, SEND=2'd1, DONE=2'd2);
  - default-width constants.
- Sub-module reg_file_dump_fsm contains the FSM, the index counter and the handshake outputs. It takes a DEPTH parameter and outputs idx.
- The top level owns the storage array, the read muxes, the bypass logic and the dump data mux.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 and read r5 on both ports -> both 0xDEADBEEF; r6 reads 0.
- Write 0x12345678 to r0 with HARDWIRE_ZERO=1 -> port reads 0.
- Same-cycle write r7=0xA5A5A5A5 while reading r7:
  - with REG_FILE_BYPASS_EN -> 0xA5A5A5A5 that cycle;
  - without it -> old value 0, then 0xA5A5A5A5 next cycle.
- Preload ri=i*3, pulse i_dump_start, ready high -> 32 words with idx 0..31 and data i*3 on consecutive cycles (word 0 = 0); o_dump_done pulses once the cycle after idx 31.
- Dump with i_dump_ready toggling 1,0,0,1,... -> idx/data held while ready=0; no word skipped or repeated; i_dump_start mid-dump ignored.
- Assert i_reset at idx=10 mid-dump -> next cycle o_dump_valid=0, o_dump_busy=0, no o_dump_done, all registers 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared definitions for the multiport register file: default widths and dump FSM state encoding.
package reg_file_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_READ   = 2;

    typedef logic [1:0] dump_state_t;

    localparam dump_state_t DUMP_IDLE = 2'd0;
    localparam dump_state_t DUMP_SEND = 2'd1;
    localparam dump_state_t DUMP_DONE = 2'd2;

endpackage

// File: rtl/reg_file_dump_fsm.sv
// Dump engine: walks every register index once over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for i_dump_start
// SEND  | presenting word idx, advances on i_dump_ready
// DONE  | one-cycle completion pulse, then back to IDLE
module reg_file_dump_fsm
    import reg_file_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic                  o_dump_valid,
    output logic                  o_dump_done,
    output logic                  o_dump_busy,
    output logic [ADDR_WIDTH-1:0] o_dump_idx
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    dump_state_t           state;
    logic [ADDR_WIDTH-1:0] idx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= DUMP_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                DUMP_IDLE: begin
                    if (i_dump_start) begin
                        state <= DUMP_SEND;
                        idx   <= '0;
                    end
                end
                DUMP_SEND: begin
                    // Leaving SEND at the last index keeps idx from wrapping
                    if (i_dump_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= DUMP_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DUMP_DONE: state <= DUMP_IDLE;
                default:   state <= DUMP_IDLE;
            endcase
        end
    end

    assign o_dump_valid = (state == DUMP_SEND);
    assign o_dump_done  = (state == DUMP_DONE);
    assign o_dump_busy  = (state != DUMP_IDLE);
    assign o_dump_idx   = idx;

endmodule

// File: rtl/reg_file_multiport.sv
// Multiport register file with hardwired-zero option and register dump engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_multiport
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int NUM_READ      = DEF_NUM_READ,
    parameter bit HARDWIRE_ZERO = 1'b1
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_write_enable,
    input  logic [ADDR_WIDTH-1:0]          i_write_reg,
    input  logic [DATA_WIDTH-1:0]          i_data_write,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] i_read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] o_read_data,
    input  logic                           i_dump_start,
    input  logic                           i_dump_ready,
    output logic                           o_dump_valid,
    output logic [ADDR_WIDTH-1:0]          o_dump_idx,
    output logic [DATA_WIDTH-1:0]          o_dump_data,
    output logic                           o_dump_done,
    output logic                           o_dump_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  write_ok;
    logic [ADDR_WIDTH-1:0] dump_idx;

    assign write_ok = i_write_enable && !(HARDWIRE_ZERO && (i_write_reg == '0));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[i_write_reg] <= i_data_write;
        end
    end

    // Shared by the read ports and the dump path so zero/bypass rules stay identical
    function automatic logic [DATA_WIDTH-1:0] read_word(input logic [ADDR_WIDTH-1:0] addr);
        if (HARDWIRE_ZERO && (addr == '0)) begin
            return '0;
        end
`ifdef REG_FILE_BYPASS_EN
        if (i_write_enable && (i_write_reg == addr)) begin
            return i_data_write;
        end
`endif
        return regs[addr];
    endfunction

    always_comb begin
        o_read_data = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            o_read_data[k*DATA_WIDTH +: DATA_WIDTH] =
                read_word(i_read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    always_comb begin
        o_dump_data = read_word(dump_idx);
    end

    assign o_dump_idx = dump_idx;

    reg_file_dump_fsm #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dump_fsm (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_done  (o_dump_done),
        .o_dump_busy  (o_dump_busy),
        .o_dump_idx   (dump_idx)
    );

endmodule

// File: tb/tb_reg_file_multiport.sv
// Directed bench for reg_file_multiport: table-driven read/write vectors plus dump sequences.
module tb_reg_file_multiport;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_write_enable;
    logic [4:0]  i_write_reg;
    logic [31:0] i_data_write;
    logic [9:0]  i_read_addr;
    logic [63:0] o_read_data;
    logic        i_dump_start;
    logic        i_dump_ready;
    logic        o_dump_valid;
    logic [4:0]  o_dump_idx;
    logic [31:0] o_dump_data;
    logic        o_dump_done;
    logic        o_dump_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_file_multiport dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_write_enable (i_write_enable),
        .i_write_reg    (i_write_reg),
        .i_data_write   (i_data_write),
        .i_read_addr    (i_read_addr),
        .o_read_data    (o_read_data),
        .i_dump_start   (i_dump_start),
        .i_dump_ready   (i_dump_ready),
        .o_dump_valid   (o_dump_valid),
        .o_dump_idx     (o_dump_idx),
        .o_dump_data    (o_dump_data),
        .o_dump_done    (o_dump_done),
        .o_dump_busy    (o_dump_busy)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
        i_write_enable = 1'b1;
        i_write_reg    = r;
        i_data_write   = d;
        tick();
        i_write_enable = 1'b0;
    endtask

    logic [31:0] mem [32];
    int          exp_idx;
    int          cyc;
    int          done_cnt;

    initial begin
        i_reset        = 1'b1;
        i_write_enable = 1'b0;
        i_write_reg    = '0;
        i_data_write   = '0;
        i_read_addr    = '0;
        i_dump_start   = 1'b0;
        i_dump_ready   = 1'b0;

        //            we    wreg   wdata          ra0    ra1    exp0                          exp1
        vecs[0]  = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd6,  32'h0,                        32'h0};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF,  5'd5,  5'd6,  BYP ? 32'hDEADBEEF : 32'h0,   32'h0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd5,  32'hDEADBEEF,                 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,         5'd6,  5'd0,  32'h0,                        32'h0};
        vecs[4]  = '{1'b1, 5'd0,  32'h12345678,  5'd0,  5'd5,  32'h0,                        32'hDEADBEEF};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h0,                        32'h0};
        vecs[6]  = '{1'b1, 5'd7,  32'hA5A5A5A5,  5'd7,  5'd5,  BYP ? 32'hA5A5A5A5 : 32'h0,   32'hDEADBEEF};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,  32'hA5A5A5A5,                 32'hA5A5A5A5};
        vecs[8]  = '{1'b1, 5'd31, 32'hFFFFFFFF,  5'd31, 5'd30, BYP ? 32'hFFFFFFFF : 32'h0,   32'h0};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd30, 32'hFFFFFFFF,                 32'h0};
        vecs[10] = '{1'b1, 5'd7,  32'h00000001,  5'd0,  5'd7,  32'h0,                        BYP ? 32'h1 : 32'hA5A5A5A5};
        vecs[11] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd31, 32'h00000001,                 32'hFFFFFFFF};

        tick();
        tick();
        i_reset = 1'b0;
        chk("reset_valid", {31'b0, o_dump_valid}, 32'h0);
        chk("reset_busy",  {31'b0, o_dump_busy},  32'h0);
        chk("reset_done",  {31'b0, o_dump_done},  32'h0);

        for (int v = 0; v < 12; v++) begin
            i_write_enable = vecs[v].we;
            i_write_reg    = vecs[v].wreg;
            i_data_write   = vecs[v].wdata;
            i_read_addr    = {vecs[v].ra1, vecs[v].ra0};
            #2;
            chk($sformatf("vec%0d_port0", v), o_read_data[31:0],  vecs[v].exp0);
            chk($sformatf("vec%0d_port1", v), o_read_data[63:32], vecs[v].exp1);
            tick();
        end
        i_write_enable = 1'b0;

        // Full-speed dump of ri = i*3
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'(i * 3);
            write_reg(5'(i), mem[i]);
        end
        i_dump_start = 1'b1;
        i_dump_ready = 1'b1;
        tick();
        i_dump_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #2;
            chk($sformatf("d1_valid%0d", k), {31'b0, o_dump_valid}, 32'h1);
            chk($sformatf("d1_idx%0d", k),   {27'b0, o_dump_idx},   32'(k));
            chk($sformatf("d1_data%0d", k),  o_dump_data,           mem[k]);
            chk($sformatf("d1_nodone%0d", k), {31'b0, o_dump_done}, 32'h0);
            tick();
        end
        #2;
        chk("d1_done",       {31'b0, o_dump_done},  32'h1);
        chk("d1_done_busy",  {31'b0, o_dump_busy},  32'h1);
        chk("d1_done_valid", {31'b0, o_dump_valid}, 32'h0);
        tick();
        #2;
        chk("d1_after_done", {31'b0, o_dump_done}, 32'h0);
        chk("d1_after_busy", {31'b0, o_dump_busy}, 32'h0);

        // Stalled dump with a mid-dump start and a write ahead of the index
        i_dump_ready = 1'b0;
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        exp_idx = 0;
        cyc     = 0;
        while (exp_idx < 32 && cyc < 300) begin
            i_dump_ready   = (cyc % 3 == 0);
            i_dump_start   = (cyc == 10);
            i_write_enable = (cyc == 5);
            i_write_reg    = 5'd20;
            i_data_write   = 32'hCAFE0000;
            #2;
            chk($sformatf("d2_valid_c%0d", cyc), {31'b0, o_dump_valid}, 32'h1);
            chk($sformatf("d2_idx_c%0d", cyc),   {27'b0, o_dump_idx},   32'(exp_idx));
            chk($sformatf("d2_data_c%0d", cyc),  o_dump_data,           mem[exp_idx]);
            tick();
            if (cyc == 5) mem[20] = 32'hCAFE0000;
            if (i_dump_ready) exp_idx++;
            cyc++;
        end
        i_dump_start   = 1'b0;
        i_write_enable = 1'b0;
        i_dump_ready   = 1'b1;
        chk("d2_timeout", 32'(exp_idx), 32'd32);
        #2;
        chk("d2_done", {31'b0, o_dump_done}, 32'h1);
        tick();
        tick();
        #2;
        chk("d2_idle_busy", {31'b0, o_dump_busy}, 32'h0);

        // Reset in the middle of a dump
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        #2;
        chk("d3_idx10", {27'b0, o_dump_idx}, 32'd10);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #2;
        chk("d3_rst_valid", {31'b0, o_dump_valid}, 32'h0);
        chk("d3_rst_busy",  {31'b0, o_dump_busy},  32'h0);
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (o_dump_done) done_cnt++;
            tick();
            #2;
        end
        chk("d3_no_done", 32'(done_cnt), 32'd0);
        for (int a = 0; a < 32; a++) begin
            i_read_addr = {5'(a), 5'(a)};
            #2;
            chk($sformatf("d3_clear_r%0d", a), o_read_data[31:0],  32'h0);
            chk($sformatf("d3_clear_p1_r%0d", a), o_read_data[63:32], 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
